// File: rtl/taxi_eth_phy_10g_tx_gbx.sv
// 66b-to-64b transmit gearbox: packs 32 sync-headed blocks into 33 SERDES words,
// inserting a stall slot every 33rd cycle to flush the accumulated leftover bits.
module taxi_eth_phy_10g_tx_gbx #(
  parameter int STALL_LEAD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] in_data,
  input  logic        in_data_valid,
  input  logic [1:0]  in_hdr,
  input  logic        in_hdr_valid,
  output logic        gbx_req_stall,
  output logic        gbx_req_sync,
  output logic [63:0] out_data,
  output logic        out_valid,
  output logic        stat_overflow,
  output logic        stat_underflow
);

  localparam logic [5:0] STALL_SLOT = 6'd32;
  localparam logic [5:0] STALL_CNT  = 6'(32 - STALL_LEAD);
  localparam logic [5:0] SYNC_CNT   = 6'((33 - STALL_LEAD) % 33);

  logic [5:0]   cnt;
  logic [63:0]  leftover;
  logic         block_ok;
  logic [65:0]  block;
  logic [127:0] combined;

  assign block_ok = in_data_valid && in_hdr_valid;
  assign block    = {in_data, in_hdr};

  // Leftover occupies the low 2*cnt bits; the new block lands directly above it.
  // At most 2*31 + 66 = 128 bits are ever live, so 128 bits of width suffice.
  assign combined = ({62'd0, block} << {cnt[4:0], 1'b0}) | {64'd0, leftover};

  assign gbx_req_stall = (cnt == STALL_CNT);
  assign gbx_req_sync  = (cnt == SYNC_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      leftover       <= '0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      stat_overflow  <= 1'b0;
      stat_underflow <= 1'b0;
    end else begin
      stat_overflow  <= 1'b0;
      stat_underflow <= 1'b0;
      if (cnt == STALL_SLOT) begin
        // Stall slot: leftover is exactly 64 bits here; any offered block is lost.
        out_data      <= leftover;
        out_valid     <= 1'b1;
        leftover      <= '0;
        cnt           <= '0;
        stat_overflow <= block_ok;
      end else if (block_ok) begin
        out_data  <= combined[63:0];
        out_valid <= 1'b1;
        leftover  <= combined[127:64];
        cnt       <= cnt + 6'd1;
      end else begin
        out_valid      <= 1'b0;
        stat_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_taxi_eth_phy_10g_tx_gbx.sv
// Randomized bench for the 10G transmit gearbox, checked against a bit-queue model
// of the serial stream plus fixed-pattern word checks.
module tb_taxi_eth_phy_10g_tx_gbx;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data;
  logic        in_data_valid;
  logic [1:0]  in_hdr;
  logic        in_hdr_valid;

  logic        stall1, sync1, valid1, ovf1, unf1;
  logic [63:0] data1;
  logic        stall0, sync0, valid0, ovf0, unf0;
  logic [63:0] data0;
  logic        stall3, sync3, valid3, ovf3, unf3;
  logic [63:0] data3;

  always #5 clk = ~clk;

  taxi_eth_phy_10g_tx_gbx #(.STALL_LEAD(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_data_valid(in_data_valid),
    .in_hdr(in_hdr), .in_hdr_valid(in_hdr_valid), .gbx_req_stall(stall1),
    .gbx_req_sync(sync1), .out_data(data1), .out_valid(valid1),
    .stat_overflow(ovf1), .stat_underflow(unf1));

  taxi_eth_phy_10g_tx_gbx #(.STALL_LEAD(0)) dut_lead0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_data_valid(in_data_valid),
    .in_hdr(in_hdr), .in_hdr_valid(in_hdr_valid), .gbx_req_stall(stall0),
    .gbx_req_sync(sync0), .out_data(data0), .out_valid(valid0),
    .stat_overflow(ovf0), .stat_underflow(unf0));

  taxi_eth_phy_10g_tx_gbx #(.STALL_LEAD(3)) dut_lead3 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_data_valid(in_data_valid),
    .in_hdr(in_hdr), .in_hdr_valid(in_hdr_valid), .gbx_req_stall(stall3),
    .gbx_req_sync(sync3), .out_data(data3), .out_valid(valid3),
    .stat_overflow(ovf3), .stat_underflow(unf3));

  int checks = 0;
  int errors = 0;

  // Reference: a serial bit queue (bit 0 first) plus the slot position in the 33-slot frame.
  logic        mq[$];
  int          mCnt;
  logic [63:0] mData;
  logic        mValid, mOvf, mUnf;

  logic        reqNow, reqPrev;
  logic [63:0] words[0:32];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic popWord();
    for (int i = 0; i < 64; i++) begin
      if (mq.size() > 0) mData[i] = mq.pop_front();
      else mData[i] = 1'b0;
    end
  endtask

  task automatic modelStep(input logic r, input logic dv, input logic hv, input logic [65:0] blk);
    logic b;
    b = dv && hv;
    if (r) begin
      mq.delete();
      mCnt = 0; mData = '0; mValid = 0; mOvf = 0; mUnf = 0;
    end else if (mCnt == 32) begin
      popWord();
      mq.delete();
      mValid = 1; mOvf = b; mUnf = 0; mCnt = 0;
    end else if (b) begin
      for (int i = 0; i < 66; i++) mq.push_back(blk[i]);
      popWord();
      mValid = 1; mOvf = 0; mUnf = 0; mCnt++;
    end else begin
      mValid = 0; mOvf = 0; mUnf = 1;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic dv, input logic hv,
                               input logic [63:0] d, input logic [1:0] h);
    rst = r; in_data_valid = dv; in_hdr_valid = hv; in_data = d; in_hdr = h;
    modelStep(r, dv, hv, {d, h});
    @(posedge clk);
    #1;
    checkOutput("out_data",       data1,  mData);
    checkOutput("out_valid",      valid1, mValid);
    checkOutput("stat_overflow",  ovf1,   mOvf);
    checkOutput("stat_underflow", unf1,   mUnf);
    checkOutput("req_stall_l1",   stall1, mCnt == 31);
    checkOutput("req_sync_l1",    sync1,  mCnt == 32);
    checkOutput("req_stall_l0",   stall0, mCnt == 32);
    checkOutput("req_sync_l0",    sync0,  mCnt == 0);
    checkOutput("req_stall_l3",   stall3, mCnt == 29);
    checkOutput("req_sync_l3",    sync3,  mCnt == 30);
    checkOutput("out_data_l0",    data0,  mData);
    checkOutput("out_data_l3",    data3,  mData);
    reqPrev = reqNow;
    reqNow  = stall1;
  endtask

  task automatic randBlock(input logic dv, input logic hv);
    applyStimulus(1'b0, dv, hv, {$urandom, $urandom}, 2'($urandom));
  endtask

  // 32 all-zero payload blocks with header 01 then an idle stall slot, starting from slot 0.
  task automatic runPattern(input string tag);
    for (int k = 0; k < 32; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 64'd0, 2'b01);
      words[k] = data1;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, 2'b00);
    words[32] = data1;
    checkOutput({tag, "_w0"},  words[0],  64'h1);
    checkOutput({tag, "_w1"},  words[1],  64'h4);
    checkOutput({tag, "_w31"}, words[31], 64'h4000_0000_0000_0000);
    checkOutput({tag, "_w32"}, words[32], 64'h0);
    checkOutput({tag, "_v32"}, valid1,    1'b1);
  endtask

  initial begin
    reqNow = 0; reqPrev = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 2'b00);
    applyStimulus(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11);
    checkOutput("rst_data", data1, 64'h0);

    runPattern("pat");

    // Stream following the STALL_LEAD=1 request, delayed one cycle.
    for (int s = 0; s < 10 * 33; s++) begin
      logic give;
      give = !reqPrev;
      randBlock(give, give);
    end

    // Block offered into the stall slot.
    for (int k = 0; k < 32; k++) randBlock(1'b1, 1'b1);
    randBlock(1'b1, 1'b1);
    checkOutput("ovf_pulse", ovf1, 1'b1);
    checkOutput("ovf_cnt0",  sync0, 1'b1);
    randBlock(1'b1, 1'b1);
    checkOutput("ovf_clear", ovf1, 1'b0);
    for (int k = 0; k < 31; k++) randBlock(1'b1, 1'b1);
    randBlock(1'b0, 1'b0);

    // Missing header valid at slot 5.
    for (int k = 0; k < 5; k++) randBlock(1'b1, 1'b1);
    randBlock(1'b1, 1'b0);
    checkOutput("unf_pulse", unf1,   1'b1);
    checkOutput("unf_valid", valid1, 1'b0);
    for (int k = 0; k < 27; k++) randBlock(1'b1, 1'b1);
    randBlock(1'b0, 1'b0);

    // Unconstrained valids, including half-valid and stall-slot offers.
    for (int k = 0; k < 100; k++) randBlock(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));

    // Reset in the middle of a sequence.
    applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 2'b00);
    for (int k = 0; k < 17; k++) randBlock(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, 2'b10);
    checkOutput("mid_rst_data",  data1,  64'h0);
    checkOutput("mid_rst_valid", valid1, 1'b0);
    runPattern("pat2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/taxi_eth_phy_10g_tx_gbx.md
TAXI_ETH_PHY_10G_TX_GBX -- requirements
Module: taxi_eth_phy_10g_tx_gbx

Interface
REQ-001 SHALL have parameter STALL_LEAD, default 1, range 0..4: cycles by which gbx_req_stall/gbx_req_sync lead the slot they announce.
REQ-002 SHALL have one clock and a synchronous, active-high reset; ports clk and rst are listed first below.
REQ-003 clk  input  1  block clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_data  input  64  scrambled 66b block payload.
REQ-006 in_data_valid  input  1  payload valid.
REQ-007 in_hdr  input  2  sync header.
REQ-008 in_hdr_valid  input  1  header valid.
REQ-009 gbx_req_stall  output  1  upstream must present no block STALL_LEAD cycles later.
REQ-010 gbx_req_sync  output  1  upstream must present block 0 of the sequence STALL_LEAD cycles later.
REQ-011 out_data  output  64  gearboxed SERDES word; bit 0 transmitted first.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 stat_overflow  output  1  one-cycle pulse: block offered in stall slot and dropped.
REQ-014 stat_underflow  output  1  one-cycle pulse: no block offered in a data slot.

Function
REQ-015 Block accepted iff in_data_valid && in_hdr_valid; one valid without the other SHALL count as no block.
REQ-016 66-bit block SHALL be ordered {in_data, in_hdr}: bit 0 = in_hdr[0], bit 1 = in_hdr[1], bit 2 = in_data[0].
REQ-017 State: slot counter cnt 0..32 and leftover register (0..64 bits, occupancy 2*cnt).
REQ-018 Data slot (cnt 0..31) with block: combined = block shifted above 2*cnt leftover bits; out_data <= combined[63:0]; leftover <= remaining 2*cnt+2 bits; cnt increments.
REQ-019 Stall slot (cnt 32): out_data <= 64 leftover bits; leftover cleared; cnt <= 0; out_valid <= 1.
REQ-020 Stall slot with block offered: block SHALL be dropped, stall-slot output unchanged, stat_overflow pulses next cycle.
REQ-021 Data slot without block: cnt and leftover hold; out_valid <= 0; out_data holds; stat_underflow pulses next cycle.
REQ-022 Latency: out_data reflects the accepted block exactly 1 cycle after acceptance; all outputs registered or decoded from cnt only.
REQ-023 gbx_req_stall SHALL be high iff cnt == (32 - STALL_LEAD).
REQ-024 gbx_req_sync SHALL be high iff cnt == (33 - STALL_LEAD) mod 33.
REQ-025 Every 33 accepted output words SHALL carry exactly 32 blocks with no bit gaps or duplication.
REQ-026 cnt wrap 32 -> 0 SHALL occur only via the stall slot; cnt never exceeds 32.

Reset
REQ-027 Under rst: cnt = 0, leftover = 0, out_data = 0, out_valid = 0, stat_overflow = 0, stat_underflow = 0.
REQ-028 Reset asserted mid-sequence SHALL discard leftover bits and partial sequence; first post-reset block enters slot 0.
REQ-029 gbx_req_stall/gbx_req_sync SHALL follow REQ-023/024 from cnt = 0 immediately after reset (STALL_LEAD=1: stall high at cnt 31, sync high at cnt 32).

Verification
REQ-030 Reset, 32 blocks data=0 hdr=2'b01, then idle -> word0 = 64'h1, word1 = 64'h4, word31 = 64'h4000_0000_0000_0000, word32 (stall) = 64'h0, all out_valid=1.
REQ-031 Random blocks driven per gbx_req_stall (STALL_LEAD=1) for 10 sequences -> concatenated output bitstream equals concatenated input blocks, no stat pulses.
REQ-032 Block offered at cnt 32 -> block dropped, stat_overflow=1 one cycle, stall word emitted, cnt=0 next.
REQ-033 in_hdr_valid=0 at cnt 5 -> out_valid=0 one cycle, stat_underflow=1, next block continues bit-exact at slot 5.
REQ-034 rst asserted at cnt 17 for 1 cycle -> all outputs zero next cycle, cnt=0, next 32 blocks reproduce REQ-030 pattern.
REQ-035 STALL_LEAD=0 and 3 -> gbx_req_stall high at cnt 32 and 29, gbx_req_sync high at cnt 0 and 30.
